// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch sequencer:
//   state_t / S_*   fetch FSM state encoding
//   PCSRC_*         redirect select encoding driven by execute
//   is_redirect()   true when pcsrc requests a PC redirect
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned PCSRC_W = 2;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_IDLE  = STATE_W'(0);
   localparam state_t S_REQ   = STATE_W'(1);
   localparam state_t S_WAIT  = STATE_W'(2);
   localparam state_t S_DRAIN = STATE_W'(3);
   localparam state_t S_HOLD  = STATE_W'(4);

   localparam logic [PCSRC_W-1:0] PCSRC_NONE   = PCSRC_W'(0);
   localparam logic [PCSRC_W-1:0] PCSRC_BRANCH = PCSRC_W'(1);
   localparam logic [PCSRC_W-1:0] PCSRC_JALR   = PCSRC_W'(2);

   // Encoding 11 is reserved and behaves like "no redirect".
   function automatic logic is_redirect(input logic [PCSRC_W-1:0] pcsrc);
      return (pcsrc == PCSRC_BRANCH) || (pcsrc == PCSRC_JALR);
   endfunction

endpackage

// File: rtl/fetch_target.sv
// ---------------------------------------------------------------------------
// fetch_target
// Combinational redirect target computation.
//   pcsrc        redirect select (none / branch-jal / jalr / reserved)
//   redir_pc     PC of the redirecting instruction
//   imm_ext      sign-extended branch/jal offset
//   alu_result   jalr target before alignment
//   redir_valid  a redirect is requested this cycle
//   target       word-aligned redirect target (adds wrap mod 2^WIDTH)
// ---------------------------------------------------------------------------
module fetch_target
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [PCSRC_W-1:0] pcsrc,
   input  logic [WIDTH-1:0]   redir_pc,
   input  logic [WIDTH-1:0]   imm_ext,
   input  logic [WIDTH-1:0]   alu_result,
   output logic               redir_valid,
   output logic [WIDTH-1:0]   target
);

   logic [WIDTH-1:0] raw;

   // Select raw target, then force word alignment for both sources.
   always_comb begin
      raw = alu_result;
      if (pcsrc == PCSRC_BRANCH) begin
         raw = redir_pc + imm_ext;
      end
      target      = raw & ~WIDTH'(3);
      redir_valid = is_redirect(pcsrc);
   end

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer: owns the PC, issues one outstanding request to
// a variable-latency instruction memory, buffers the returned word for decode
// and applies redirects from execute, discarding stale responses.
//   clk, rst_n                     clock, async active-low reset
//   pcsrc/redir_pc/imm_ext/
//   alu_result                     redirect controls from execute
//   imem_req/imem_addr/imem_gnt    request channel (addr = pc)
//   imem_rvalid/imem_rdata         response channel
//   if_valid/if_ready              decode handshake
//   if_instr/if_pc/if_pc_plus4     buffered instruction, its address, link
// ---------------------------------------------------------------------------
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned     WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         pcsrc,
   input  logic [WIDTH-1:0]   redir_pc,
   input  logic [WIDTH-1:0]   imm_ext,
   input  logic [WIDTH-1:0]   alu_result,
   output logic               imem_req,
   output logic [WIDTH-1:0]   imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [WIDTH-1:0]   imem_rdata,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [WIDTH-1:0]   if_instr,
   output logic [WIDTH-1:0]   if_pc,
   output logic [WIDTH-1:0]   if_pc_plus4
);

   logic             redir_valid;
   logic [WIDTH-1:0] target;

   state_t           state,     state_d;
   logic [WIDTH-1:0] pc,        pc_d;
   logic [WIDTH-1:0] buf_instr, buf_instr_d;
   logic [WIDTH-1:0] buf_pc,    buf_pc_d;
   logic             buf_valid, buf_valid_d;

   fetch_target #(.WIDTH(WIDTH)) u_target (
      .pcsrc       (pcsrc),
      .redir_pc    (redir_pc),
      .imm_ext     (imm_ext),
      .alu_result  (alu_result),
      .redir_valid (redir_valid),
      .target      (target)
   );

   // State, PC and output buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         buf_instr <= '0;
         buf_pc    <= '0;
         buf_valid <= 1'b0;
      end else begin
         state     <= state_d;
         pc        <= pc_d;
         buf_instr <= buf_instr_d;
         buf_pc    <= buf_pc_d;
         buf_valid <= buf_valid_d;
      end
   end

   // Next-state logic; a redirect always overrides sequential advance.
   always_comb begin
      state_d     = state;
      pc_d        = pc;
      buf_instr_d = buf_instr;
      buf_pc_d    = buf_pc;
      buf_valid_d = buf_valid;

      case (state)
         S_IDLE: begin
            state_d = S_REQ;
            if (redir_valid) pc_d = target;
         end
         S_REQ: begin
            if (redir_valid) pc_d = target;
            // A granted request that was redirected must have its response drained.
            if (imem_gnt) state_d = redir_valid ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            if (redir_valid) begin
               pc_d    = target;
               state_d = imem_rvalid ? S_REQ : S_DRAIN;
            end else if (imem_rvalid) begin
               buf_instr_d = imem_rdata;
               buf_pc_d    = pc;
               buf_valid_d = 1'b1;
               state_d     = S_HOLD;
            end
         end
         S_DRAIN: begin
            if (redir_valid) pc_d = target;
            if (imem_rvalid) state_d = S_REQ;
         end
         S_HOLD: begin
            if (redir_valid || if_ready) begin
               pc_d        = redir_valid ? target : pc + WIDTH'(4);
               buf_instr_d = '0;
               buf_pc_d    = '0;
               buf_valid_d = 1'b0;
               state_d     = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req    = (state == S_REQ);
   assign imem_addr   = pc;
   // Wrong-path word is hidden in the same cycle the redirect appears.
   assign if_valid    = buf_valid && !redir_valid;
   assign if_instr    = buf_instr;
   assign if_pc       = buf_pc;
   assign if_pc_plus4 = buf_pc + WIDTH'(4);

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. The bench plays the instruction memory;
// granted addresses go into a scoreboard queue and are popped when the
// buffered instruction is presented to decode.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic [1:0]  pcsrc;
   logic [31:0] redir_pc;
   logic [31:0] imm_ext;
   logic [31:0] alu_result;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] sb_q[$];

   fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pcsrc       (pcsrc),
      .redir_pc    (redir_pc),
      .imm_ext     (imm_ext),
      .alu_result  (alu_result),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .if_pc_plus4 (if_pc_plus4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Memory contents as a function of address.
   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Wait for a request, optionally hold off the grant, then grant it.
   task automatic issue(input logic [31:0] a, input int gd, input int exp_wait);
      int w;
      w = 0;
      #1;
      while (!imem_req && w < 20) begin
         tick();
         #1;
         w++;
      end
      check("req_wait", 32'(w), 32'(exp_wait));
      for (int i = 0; i < gd; i++) begin
         check("addr_hold", imem_addr, a);
         check("req_hold", 32'(imem_req), 32'd1);
         tick();
         #1;
      end
      imem_gnt = 1'b1;
      #1;
      check("req_addr", imem_addr, a);
      sb_q.push_back(a);
      tick();
      imem_gnt = 1'b0;
   endtask

   // Return the response after rd idle cycles, stall decode for sd cycles, accept.
   task automatic complete(input int rd, input int sd);
      logic [31:0] e;
      for (int i = 0; i < rd; i++) begin
         #1;
         check("wait_valid", 32'(if_valid), 32'd0);
         check("wait_req", 32'(imem_req), 32'd0);
         tick();
      end
      check("sb_level", 32'(sb_q.size()), 32'd1);
      e = (sb_q.size() != 0) ? sb_q[0] : 32'hDEAD_BEEF;
      imem_rvalid = 1'b1;
      imem_rdata  = word(e);
      #1;
      check("rv_valid", 32'(if_valid), 32'd0);
      tick();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (sb_q.size() != 0) e = sb_q.pop_front();
      for (int i = 0; i < sd; i++) begin
         #1;
         check("stall_valid", 32'(if_valid), 32'd1);
         check("stall_pc", if_pc, e);
         check("stall_instr", if_instr, word(e));
         check("stall_req", 32'(imem_req), 32'd0);
         tick();
      end
      if_ready = 1'b1;
      #1;
      check("out_valid", 32'(if_valid), 32'd1);
      check("out_pc", if_pc, e);
      check("out_instr", if_instr, word(e));
      check("out_pc4", if_pc_plus4, e + 32'd4);
      tick();
      if_ready = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      pcsrc       = 2'b00;
      redir_pc    = '0;
      imm_ext     = '0;
      alu_result  = '0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if_ready    = 1'b0;

      // Reset state.
      repeat (3) tick();
      #1;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(if_valid), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_instr", if_instr, 32'h0);
      tick();
      rst_n = 1'b1;
      #1;
      check("idle_req", 32'(imem_req), 32'd0);
      tick();

      // 1: best-case back-to-back fetches, one per 3 cycles.
      issue(32'h0, 0, 0);  complete(0, 0);
      issue(32'h4, 0, 0);  complete(0, 0);
      issue(32'h8, 0, 0);  complete(0, 0);

      // 2: late grant, slow memory, decode stall.
      issue(32'hC, 2, 0);  complete(5, 4);

      // 3: branch while waiting; stale word dropped.
      issue(32'h10, 0, 0);
      pcsrc    = 2'b01;
      redir_pc = 32'h10;
      imm_ext  = 32'hFFFF_FFF8;
      #1;
      check("br_valid", 32'(if_valid), 32'd0);
      check("br_req", 32'(imem_req), 32'd0);
      tick();
      pcsrc = 2'b00;
      imem_rvalid = 1'b1;
      imem_rdata  = word(32'h10);
      #1;
      check("stale_valid", 32'(if_valid), 32'd0);
      tick();
      imem_rvalid = 1'b0;
      sb_q.delete();
      issue(32'h8, 0, 0);  complete(0, 0);

      // 4: jalr kills held word even with decode ready.
      issue(32'hC, 0, 0);
      imem_rvalid = 1'b1;
      imem_rdata  = word(32'hC);
      tick();
      imem_rvalid = 1'b0;
      #1;
      check("hold_valid", 32'(if_valid), 32'd1);
      check("hold_pc", if_pc, sb_q.pop_front());
      if_ready   = 1'b1;
      pcsrc      = 2'b10;
      alu_result = 32'h103;
      #1;
      check("kill_valid", 32'(if_valid), 32'd0);
      tick();
      pcsrc    = 2'b00;
      if_ready = 1'b0;
      issue(32'h100, 0, 0);  complete(0, 0);

      // 5: redirects stacked in DRAIN; latest target wins.
      issue(32'h104, 0, 0);
      pcsrc      = 2'b10;
      alu_result = 32'h201;
      tick();
      pcsrc    = 2'b01;
      redir_pc = 32'h3C;
      imm_ext  = 32'h6;
      #1;
      check("drain_req0", 32'(imem_req), 32'd0);
      tick();
      redir_pc = 32'h100;
      imm_ext  = 32'hFFFF_FF80;
      tick();
      pcsrc = 2'b00;
      #1;
      check("drain_req1", 32'(imem_req), 32'd0);
      tick();
      imem_rvalid = 1'b1;
      imem_rdata  = word(32'h104);
      #1;
      check("drain_valid", 32'(if_valid), 32'd0);
      tick();
      imem_rvalid = 1'b0;
      sb_q.delete();
      issue(32'h80, 0, 0);  complete(0, 0);

      // 6: reset during WAIT; late response in IDLE is ignored.
      issue(32'h84, 0, 0);
      rst_n = 1'b0;
      #1;
      check("arst_req", 32'(imem_req), 32'd0);
      check("arst_valid", 32'(if_valid), 32'd0);
      tick();
      rst_n       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = word(32'h84);
      #1;
      check("idle_rv_req", 32'(imem_req), 32'd0);
      check("idle_rv_valid", 32'(if_valid), 32'd0);
      tick();
      imem_rvalid = 1'b0;
      sb_q.delete();
      issue(32'h0, 0, 0);  complete(0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
